// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - test-pattern pixel source (bars, checker, bouncing box, solid); VGA_PAT_GRID_EN adds a white grid
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32,
  parameter int BOX_STEP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       video_on,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       frame_start,
  input  logic       mode_btn,
  output logic [3:0] out_r,
  output logic [3:0] out_g,
  output logic [3:0] out_b,
  output logic [1:0] mode
);

  localparam logic [10:0] SIZE_W = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_W = 11'(BOX_STEP);
  localparam logic [10:0] H_W    = 11'(H_ACTIVE);
  localparam logic [10:0] V_W    = 11'(V_ACTIVE);
  localparam logic [9:0]  BAR_W  = 10'(H_ACTIVE / 8);

  logic [1:0]  mode_q;
  logic        btn_q;
  logic [9:0]  box_x_q, box_y_q, box_x_d, box_y_d;
  logic        dir_x_neg_q, dir_y_neg_q, dir_x_neg_d, dir_y_neg_d;
  logic [11:0] frame_col_q;
  logic [11:0] out_q, out_d;
  logic [11:0] pat;
  logic [2:0]  bar;
  logic        in_box;

  // Returns {new_dir_neg, new_pos}; bounces clamp to the edge instead of overshooting.
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic neg,
                                            input logic [10:0] limit);
    logic [10:0] p;
    logic [10:0] edge_pos;
    logic [10:0] np;
    logic        nn;
    p        = {1'b0, pos};
    edge_pos = limit - SIZE_W;
    nn       = neg;
    if (!neg) begin
      if (p + SIZE_W + STEP_W > limit) begin
        np = edge_pos;
        nn = 1'b1;
      end else begin
        np = p + STEP_W;
      end
    end else if (p < STEP_W) begin
      np = 11'd0;
      nn = 1'b0;
    end else begin
      np = p - STEP_W;
    end
    return {nn, np[9:0]};
  endfunction

  always_comb begin
    {dir_x_neg_d, box_x_d} = step_axis(box_x_q, dir_x_neg_q, H_W);
    {dir_y_neg_d, box_y_d} = step_axis(box_y_q, dir_y_neg_q, V_W);
  end

  always_comb begin
    bar    = 3'(x / BAR_W);
    in_box = ({1'b0, x} >= {1'b0, box_x_q}) && ({1'b0, x} < {1'b0, box_x_q} + SIZE_W) &&
             ({1'b0, y} >= {1'b0, box_y_q}) && ({1'b0, y} < {1'b0, box_y_q} + SIZE_W);
    pat = 12'h000;
    case (mode_q)
      2'd0:    pat = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
      2'd1:    pat = (x[5] ^ y[5]) ? 12'hFFF : 12'h000;
      2'd2:    pat = in_box ? 12'hF00 : 12'h00F;
      default: pat = frame_col_q;
    endcase
`ifdef VGA_PAT_GRID_EN
    if (x[5:0] == 6'd0 || y[5:0] == 6'd0) pat = 12'hFFF;
`else
`endif
    out_d = video_on ? pat : 12'h000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q      <= 2'd0;
      btn_q       <= 1'b0;
      box_x_q     <= 10'd0;
      box_y_q     <= 10'd0;
      dir_x_neg_q <= 1'b0;
      dir_y_neg_q <= 1'b0;
      frame_col_q <= 12'h000;
      out_q       <= 12'h000;
    end else begin
      btn_q <= mode_btn;
      if (mode_btn && !btn_q) mode_q <= mode_q + 2'd1;
      if (frame_start) begin
        frame_col_q <= frame_col_q + 12'd1;
        box_x_q     <= box_x_d;
        box_y_q     <= box_y_d;
        dir_x_neg_q <= dir_x_neg_d;
        dir_y_neg_q <= dir_y_neg_d;
      end
      if (pix_en) out_q <= out_d;
    end
  end

  assign out_r = out_q[11:8];
  assign out_g = out_q[7:4];
  assign out_b = out_q[3:0];
  assign mode  = mode_q;

endmodule
